sc_stage_scheduler: RTL and testbench

Parametrised stage/pass scheduler for the SC polar decoder datapath. It walks the full SC decoding tree for one frame of 2^N_LOG bits and issues one operation per handshake: F or G at a given stage and pass, or LEAF for a 2^LEAF_LOG-bit leaf decision. It replaces free-running stage counting with a valid/ready op stream, and adds frame start, abort and done signalling plus multi-bit leaves. It sits between the frame-level control and the PE array / leaf decision unit.

---
 rtl/sc_sched_pkg.sv | 37 +++
 rtl/sc_lsb_pos.sv | 30 +++
 rtl/sc_stage_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_sc_stage_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_sched_pkg.sv
// -----------------------------------------------------------------------------
// sc_sched_pkg
// Shared types and helpers for the SC polar decoder stage scheduler.
//   op_type_e    : operation issued to the PE array / leaf unit (F, G, LEAF)
//   state_e      : scheduler walk state
//   stage_width(): bit width of a stage index for a 2^n_log-bit frame
//   passes()     : number of PE-array passes needed at a given stage
// -----------------------------------------------------------------------------
package sc_sched_pkg;

   localparam int unsigned OP_TYPE_W = 2;

   typedef enum logic [OP_TYPE_W-1:0] {
      OP_F    = 2'd0,
      OP_G    = 2'd1,
      OP_LEAF = 2'd2
   } op_type_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OPS  = 2'd1,
      ST_LEAF = 2'd2
   } state_e;

   // Stage indices run 0..n_log-1; never narrower than one bit.
   function automatic int unsigned stage_width(input int unsigned n_log);
      return (n_log <= 1) ? 1 : $clog2(n_log);
   endfunction

   // A stage producing 2^s outputs on 2^p_log PEs needs 2^(s-p_log) passes,
   // or a single pass once the stage fits in the array.
   function automatic int unsigned passes(input int unsigned s,
                                          input int unsigned p_log);
      return (s >= p_log) ? (32'd1 << (s - p_log)) : 32'd1;
   endfunction

endpackage

// File: rtl/sc_lsb_pos.sv
// -----------------------------------------------------------------------------
// sc_lsb_pos
// Combinational lowest-set-bit position encoder. Used by the scheduler to find
// the stage at which a G operation re-enters the tree after a leaf group.
// Ports:
//   vec [N_LOG-1:0]              input vector
//   pos [stage_width(N_LOG)-1:0] index of the lowest set bit (0 when vec==0)
// -----------------------------------------------------------------------------
module sc_lsb_pos
   import sc_sched_pkg::*;
#(
   parameter int unsigned N_LOG = 3
) (
   input  logic [N_LOG-1:0]              vec,
   output logic [stage_width(N_LOG)-1:0] pos
);

   localparam int unsigned SW = stage_width(N_LOG);

   // Scan from the MSB down so the last hit, the lowest set bit, wins.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      pos = '0;
      for (int i = N_LOG - 1; i >= 0; i--) begin
         if (vec[i]) pos = SW'(i);
      end
   end

endmodule

// File: rtl/sc_stage_scheduler.sv
// -----------------------------------------------------------------------------
// sc_stage_scheduler
// Walks the full SC decoding tree of one 2^N_LOG-bit frame and issues one
// operation (F/G at a stage and pass, or a 2^LEAF_LOG-bit LEAF decision) per
// valid/ready handshake.
//
// Optional feature: define SC_SCHED_PERF_CNT_EN to add the perf_cycles output,
// a busy-cycle counter (stalls included) cleared at start and frozen at
// frame_done/abort.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         begin frame (accepted in IDLE only)
//   abort         synchronous abort, highest priority
//   busy          frame in progress
//   op_valid      op fields valid
//   op_ready      consumer accepts op
//   op_type       0=F, 1=G, 2=LEAF
//   op_stage      stage s (output length 2^s); LEAF_LOG for LEAF
//   op_exe        remaining passes at this stage, counts down to 1
//   op_bit        first bit index of the current leaf group
//   frame_done    one-cycle pulse after the last LEAF handshake
//   perf_cycles   (SC_SCHED_PERF_CNT_EN only) busy-cycle count
// -----------------------------------------------------------------------------
module sc_stage_scheduler
   import sc_sched_pkg::*;
#(
   parameter int unsigned N_LOG    = 3,
   parameter int unsigned P_LOG    = 1,
   parameter int unsigned LEAF_LOG = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   output logic                          busy,
   output logic                          op_valid,
   input  logic                          op_ready,
   output logic [OP_TYPE_W-1:0]          op_type,
   output logic [stage_width(N_LOG)-1:0] op_stage,
   output logic [N_LOG-P_LOG-1:0]        op_exe,
   output logic [N_LOG-1:0]              op_bit,
   output logic                          frame_done
`ifdef SC_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]                   perf_cycles
`endif
);

   localparam int unsigned SW    = stage_width(N_LOG);
   localparam int unsigned EXE_W = N_LOG - P_LOG;
   localparam int unsigned G_W   = N_LOG - LEAF_LOG;

   localparam logic [SW-1:0]    TOP_STAGE  = SW'(N_LOG - 1);
   localparam logic [SW-1:0]    LEAF_STAGE = SW'(LEAF_LOG);
   localparam logic [EXE_W-1:0] TOP_EXE    = EXE_W'(passes(N_LOG - 1, P_LOG));
   localparam logic [G_W-1:0]   G_LAST     = '1;

   state_e         state;
   op_type_e       type_q;
   logic [G_W-1:0] g;

   logic           handshake;
   logic [G_W-1:0] g_inc;
   logic [SW-1:0]  lsb_pos;
   logic [SW-1:0]  reentry_stage;
   logic [EXE_W-1:0] reentry_exe;
   logic [EXE_W-1:0] down_exe;

   assign handshake = op_valid & op_ready;
   assign g_inc     = g + G_W'(1);

   // The next leaf group g+1 shares its ancestors with group g up to the
   // lowest set bit of g+1; the G op re-enters the tree at that height.
   sc_lsb_pos #(
      .N_LOG (N_LOG)
   ) u_lsb_pos (
      .vec (N_LOG'(g_inc)),
      .pos (lsb_pos)
   );

   assign reentry_stage = LEAF_STAGE + lsb_pos;
   assign reentry_exe   = EXE_W'(passes(32'(reentry_stage), P_LOG));
   assign down_exe      = EXE_W'(passes(32'(op_stage) - 32'd1, P_LOG));

   assign op_type = type_q;
   assign op_bit  = N_LOG'(g) << LEAF_LOG;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         op_valid   <= 1'b0;
         type_q     <= OP_F;
         op_stage   <= TOP_STAGE;
         op_exe     <= TOP_EXE;
         g          <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (abort) begin
            // Abort wins over start and over a simultaneous handshake.
            state    <= ST_IDLE;
            busy     <= 1'b0;
            op_valid <= 1'b0;
            type_q   <= OP_F;
            op_stage <= TOP_STAGE;
            op_exe   <= TOP_EXE;
            g        <= '0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (start) begin
                     state    <= ST_OPS;
                     busy     <= 1'b1;
                     op_valid <= 1'b1;
                     type_q   <= OP_F;
                     op_stage <= TOP_STAGE;
                     op_exe   <= TOP_EXE;
                     g        <= '0;
                  end
               end
               ST_OPS: begin
                  if (handshake) begin
                     if (op_exe > EXE_W'(1)) begin
                        op_exe <= op_exe - EXE_W'(1);
                     end else if (op_stage > LEAF_STAGE) begin
                        type_q   <= OP_F;
                        op_stage <= op_stage - SW'(1);
                        op_exe   <= down_exe;
                     end else begin
                        state    <= ST_LEAF;
                        type_q   <= OP_LEAF;
                        op_stage <= LEAF_STAGE;
                        op_exe   <= EXE_W'(1);
                     end
                  end
               end
               ST_LEAF: begin
                  if (handshake) begin
                     if (g == G_LAST) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        op_valid   <= 1'b0;
                        type_q     <= OP_F;
                        op_stage   <= TOP_STAGE;
                        op_exe     <= TOP_EXE;
                        g          <= '0;
                        frame_done <= 1'b1;
                     end else begin
                        state    <= ST_OPS;
                        type_q   <= OP_G;
                        op_stage <= reentry_stage;
                        op_exe   <= reentry_exe;
                        g        <= g_inc;
                     end
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  op_valid <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SC_SCHED_PERF_CNT_EN
   // Counts every cycle with busy high; busy drops with frame_done/abort,
   // which freezes the value until the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cycles <= '0;
      end else if (state == ST_IDLE && start && !abort) begin
         perf_cycles <= '0;
      end else if (busy && !abort) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sc_stage_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sc_stage_scheduler
// Scoreboard bench for sc_stage_scheduler. The expected op stream of a frame is
// generated leaf group by leaf group from the tree rules and queued at start;
// a negedge monitor pops and compares on every handshake and checks field
// stability during stalls. A second instance (N_LOG=4, P_LOG=0, LEAF_LOG=2)
// covers multi-bit leaves.
// -----------------------------------------------------------------------------
module tb_sc_stage_scheduler;

   typedef struct {
      int typ;
      int stage;
      int exe;
      int bit_idx;
   } op_t;

   logic clk = 1'b0;
   logic rst;
   logic start, abort, op_ready;
   logic busy, op_valid, frame_done;
   logic [1:0] op_type;
   logic [1:0] op_stage;
   logic [1:0] op_exe;
   logic [2:0] op_bit;
`ifdef SC_SCHED_PERF_CNT_EN
   logic [31:0] perf_cycles;
   logic [31:0] perf_b;
`endif

   logic start_b;
   logic busy_b, valid_b, done_b;
   logic [1:0] type_b;
   logic [1:0] stage_b;
   logic [3:0] exe_b;
   logic [3:0] bit_b;

   int n_checks = 0;
   int n_err    = 0;
   int stall_cnt = 0;

   op_t exp_q[$];
   op_t model_q[$];

   always #5 clk = ~clk;

   sc_stage_scheduler #(.N_LOG(3), .P_LOG(1), .LEAF_LOG(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_type    (op_type),
      .op_stage   (op_stage),
      .op_exe     (op_exe),
      .op_bit     (op_bit),
      .frame_done (frame_done)
`ifdef SC_SCHED_PERF_CNT_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   sc_stage_scheduler #(.N_LOG(4), .P_LOG(0), .LEAF_LOG(2)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .start      (start_b),
      .abort      (1'b0),
      .busy       (busy_b),
      .op_valid   (valid_b),
      .op_ready   (1'b1),
      .op_type    (type_b),
      .op_stage   (stage_b),
      .op_exe     (exe_b),
      .op_bit     (bit_b),
      .frame_done (done_b)
`ifdef SC_SCHED_PERF_CNT_EN
      ,
      .perf_cycles (perf_b)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int npasses(input int s, input int p);
      return (s >= p) ? (1 << (s - p)) : 1;
   endfunction

   task automatic emit(input int typ, input int s, input int p, input int bit_idx);
      op_t o;
      for (int e = npasses(s, p); e >= 1; e--) begin
         o.typ = typ; o.stage = s; o.exe = e; o.bit_idx = bit_idx;
         model_q.push_back(o);
      end
   endtask

   // Per leaf group g: group 0 descends with F from the root; any later group
   // starts with G at the height of its lowest set bit, then descends with F.
   task automatic build_model(input int n, input int p, input int l);
      op_t o;
      int  top, tz, v;
      model_q.delete();
      for (int g = 0; g < (1 << (n - l)); g++) begin
         if (g == 0) begin
            top = n - 1;
         end else begin
            tz = 0;
            v  = g;
            while (v % 2 == 0) begin
               v  = v / 2;
               tz = tz + 1;
            end
            emit(1, l + tz, p, g << l);
            top = l + tz - 1;
         end
         for (int s = top; s >= l; s--) emit(0, s, p, g << l);
         o.typ = 2; o.stage = l; o.exe = 0; o.bit_idx = g << l;
         model_q.push_back(o);
      end
   endtask

   // Monitor: stall accounting, stall stability and scoreboard pops.
   op_t prev;
   bit  have_prev = 1'b0;
   always @(negedge clk) begin
      op_t e;
      if (!rst) begin
         if (busy && op_valid && !op_ready) stall_cnt++;
         if (have_prev && op_valid) begin
            check("stall_type",  int'(op_type),  prev.typ);
            check("stall_stage", int'(op_stage), prev.stage);
            check("stall_exe",   int'(op_exe),   prev.exe);
            check("stall_bit",   int'(op_bit),   prev.bit_idx);
         end
         have_prev = op_valid && !op_ready && !abort;
         prev.typ = int'(op_type); prev.stage = int'(op_stage);
         prev.exe = int'(op_exe);  prev.bit_idx = int'(op_bit);
         if (op_valid && op_ready && !abort) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_op: type %0d stage %0d with empty queue",
                        op_type, op_stage);
            end else begin
               e = exp_q.pop_front();
               check("op_type",  int'(op_type),  e.typ);
               check("op_stage", int'(op_stage), e.stage);
               if (e.typ != 2) check("op_exe", int'(op_exe), e.exe);
               check("op_bit",   int'(op_bit),   e.bit_idx);
            end
         end
      end else begin
         have_prev = 1'b0;
      end
   end

   function automatic logic pick_ready(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 2) == 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // mode 0: ready high, 1: ready toggling, 2: random ready,
   // 3: random ready with random start pulses while busy.
   task automatic run_frame(input int mode, input string tag, output int cycles);
      build_model(3, 1, 0);
      exp_q     = model_q;
      stall_cnt = 0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_after_start"},  int'(busy),       1);
      check({tag, "_valid_after_start"}, int'(op_valid),   1);
      check({tag, "_no_done_at_start"},  int'(frame_done), 0);
      cycles = 0;
      while (!frame_done && cycles < 400) begin
         op_ready = pick_ready(mode, cycles);
         if (mode == 3) start = 1'($urandom_range(0, 1));
         tick();
         cycles++;
      end
      start    = 1'b0;
      op_ready = 1'b1;
      check({tag, "_frame_done"},    int'(frame_done), 1);
      check({tag, "_busy_at_done"},  int'(busy),       0);
      check({tag, "_valid_at_done"}, int'(op_valid),   0);
      check({tag, "_ops_left"},      exp_q.size(),     0);
`ifdef SC_SCHED_PERF_CNT_EN
      check({tag, "_perf_cycles"}, int'(perf_cycles), 24 + stall_cnt);
`endif
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},     int'(busy),       0);
      check({tag, "_valid"},    int'(op_valid),   0);
      check({tag, "_type"},     int'(op_type),    0);
      check({tag, "_stage"},    int'(op_stage),   2);
      check({tag, "_exe"},      int'(op_exe),     2);
      check({tag, "_bit"},      int'(op_bit),     0);
      check({tag, "_done"},     int'(frame_done), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      rst = 1'b1; start = 1'b0; abort = 1'b0; op_ready = 1'b1; start_b = 1'b0;
      #1;
      check_reset_values("rst");
      check("rst_b_stage", int'(stage_b), 3);
      check("rst_b_exe",   int'(exe_b),   8);
`ifdef SC_SCHED_PERF_CNT_EN
      check("rst_perf", int'(perf_cycles), 0);
`endif
      tick(); tick();
      rst = 1'b0;
      tick();

      // Full frame, ready held high: 24 ops, frame_done 24 cycles later.
      run_frame(0, "full", cyc);
      check("full_latency", cyc, 24);
      // Restart in the frame_done cycle, ready toggling.
      run_frame(1, "toggle", cyc);
`ifdef SC_SCHED_PERF_CNT_EN
      begin
         int frozen;
         frozen = int'(perf_cycles);
         tick(); tick(); tick();
         check("perf_frozen", int'(perf_cycles), frozen);
      end
`endif
      tick();
      check("done_is_pulse", int'(frame_done), 0);

      // Random ready.
      for (int k = 0; k < 3; k++) run_frame(2, "random", cyc);

      // Abort while the 5th op is being handshaken.
      build_model(3, 1, 0);
      exp_q = model_q;
      start = 1'b1;
      tick();
      start = 1'b0;
      op_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_valid",    int'(op_valid),   0);
      check("abort_busy",     int'(busy),       0);
      check("abort_done",     int'(frame_done), 0);
      check("abort_consumed", 24 - exp_q.size(), 4);
      exp_q.delete();
      tick();
      check("abort_done_later", int'(frame_done), 0);
      run_frame(0, "after_abort", cyc);
      check("after_abort_latency", cyc, 24);
      tick();

      // Start pulses while busy are ignored.
      run_frame(3, "start_busy", cyc);
      tick();

      // start together with abort in IDLE stays idle.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy",  int'(busy),     0);
      check("start_abort_valid", int'(op_valid), 0);
      tick();
      check("start_abort_busy2", int'(busy),     0);

      // Reset mid-frame.
      build_model(3, 1, 0);
      exp_q = model_q;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      #1;
      rst = 1'b0;
      exp_q.delete();
      tick();
      check("midrst_idle_busy", int'(busy),       0);
      check("midrst_idle_done", int'(frame_done), 0);
      run_frame(0, "after_rst", cyc);
      check("after_rst_latency", cyc, 24);

      // Multi-bit leaves: N_LOG=4, P_LOG=0, LEAF_LOG=2.
      build_model(4, 0, 2);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      check("b_busy", int'(busy_b), 1);
      foreach (model_q[i]) begin
         check("b_valid", int'(valid_b), 1);
         check("b_type",  int'(type_b),  model_q[i].typ);
         check("b_stage", int'(stage_b), model_q[i].stage);
         if (model_q[i].typ != 2) check("b_exe", int'(exe_b), model_q[i].exe);
         check("b_bit",   int'(bit_b),   model_q[i].bit_idx);
         tick();
      end
      check("b_frame_done", int'(done_b), 1);
      check("b_busy_done",  int'(busy_b), 0);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
